// File: rtl/prom_pkg.sv
// Shared constants and state encoding for the parameter-PROM auto-load front end.
package prom_pkg;

  localparam int          NWORDS   = 34;
  localparam logic [15:0] HEADER   = 16'h4321;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int          CNT_W    = 10;
  localparam int          WIDX_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_DATA    = 3'd2,
    ST_CRCW    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ABORTED = 3'd5
  } state_t;

endpackage

// File: rtl/prom_param_reader_if.sv
// Signal bundle between the PROM pins / auto-load FIFO side (master) and the reader (slave).
// Handshake: WORD_VLD is a one-cycle write strobe for WORD; FF_FULL is advisory only (the
// PROM cannot pause), so a word completing while FF_FULL=1 is dropped and STALL latches.
interface prom_param_reader_if;
  import prom_pkg::*;

  logic [7:0]       PARAM_DAT;
  logic             DECODE;
  logic             CRC_ENA;
  logic             FF_FULL;
  logic [15:0]      WORD;
  logic             WORD_VLD;
  logic             HDR_OK;
  logic             ABORT;
  logic             SEQ_DONE;
  logic             CRC_ERR;
  logic             VOTE_ERR;
  logic             STALL;
  logic [CNT_W-1:0] BYTE_CNT;
  state_t           state_dbg;

  modport master (
    output PARAM_DAT, DECODE, CRC_ENA, FF_FULL,
    input  WORD, WORD_VLD, HDR_OK, ABORT, SEQ_DONE, CRC_ERR, VOTE_ERR, STALL,
           BYTE_CNT, state_dbg
  );

  modport slave (
    input  PARAM_DAT, DECODE, CRC_ENA, FF_FULL,
    output WORD, WORD_VLD, HDR_OK, ABORT, SEQ_DONE, CRC_ERR, VOTE_ERR, STALL,
           BYTE_CNT, state_dbg
  );

endinterface

// File: rtl/crc16_word.sv
// Combinational next-CRC: folds one 16-bit word, MSB first, into a CRC-16 register.
module crc16_word
  import prom_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] word_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ word_in[i]) ? CRC_POLY : 16'h0000);
    end
    crc_out = c;
  end

endmodule

// File: rtl/prom_param_reader.sv
// Assembles PROM bytes into 16-bit parameter words (optional triple-copy vote and CRC check)
// and strobes them towards the auto-load FIFO, flagging header, completion and error status.
module prom_param_reader
  import prom_pkg::*;
(
  input  logic          PARAM_CLK,
  input  logic          prm_rst,
  prom_param_reader_if.slave bus
);

  // Reset asserts asynchronously and releases two edges later, in step with the PROM address.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge PARAM_CLK or posedge prm_rst) begin
    if (prm_rst) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_i = rst_sync[1];

  state_t              state, state_nxt;
  logic [2:0]          phase;
  logic [7:0]          lo_byte;
  logic [15:0]         copy0, copy1;
  logic [WIDX_W-1:0]   widx;
  logic [15:0]         crc;
  logic [15:0]         crc_next;
  logic                decode_q, crc_ena_q;
  logic [15:0]         word_r;
  logic                vld_r, hdr_ok_r, abort_r, done_r, crc_err_r, vote_err_r, stall_r;
  logic [CNT_W-1:0]    byte_cnt;

  logic                active, decode_eff, last_byte, word_done, crc_done;
  logic [15:0]         cur_word, voted, data_word;

  always_comb begin
    active     = (state == ST_IDLE) || (state == ST_HDR) ||
                 (state == ST_DATA) || (state == ST_CRCW);
    // Mode inputs are only captured on the first edge after release, which happens in IDLE.
    decode_eff = (state == ST_IDLE) ? bus.DECODE : decode_q;
    cur_word   = {bus.PARAM_DAT, lo_byte};
    voted      = (copy0 & copy1) | (copy0 & cur_word) | (copy1 & cur_word);
    data_word  = decode_eff ? voted : cur_word;
    if ((state == ST_CRCW) || !decode_eff) last_byte = active && (phase == 3'd1);
    else                                   last_byte = active && (phase == 3'd5);
    word_done  = last_byte && ((state == ST_HDR) || (state == ST_DATA));
    crc_done   = last_byte && (state == ST_CRCW);
  end

  crc16_word u_crc (
    .crc_in  (crc),
    .word_in (data_word),
    .crc_out (crc_next)
  );

  always_ff @(posedge PARAM_CLK or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_HDR;
      ST_HDR: begin
        if (word_done) state_nxt = (data_word == HEADER) ? ST_DATA : ST_ABORTED;
      end
      ST_DATA: begin
        if (word_done && (widx == WIDX_W'(NWORDS - 1)))
          state_nxt = crc_ena_q ? ST_CRCW : ST_DONE;
      end
      ST_CRCW: begin
        if (crc_done) state_nxt = ST_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge PARAM_CLK or posedge rst_i) begin
    if (rst_i) begin
      phase      <= 3'd0;
      lo_byte    <= 8'h00;
      copy0      <= 16'h0000;
      copy1      <= 16'h0000;
      widx       <= '0;
      crc        <= CRC_INIT;
      decode_q   <= 1'b0;
      crc_ena_q  <= 1'b0;
      word_r     <= 16'h0000;
      vld_r      <= 1'b0;
      hdr_ok_r   <= 1'b0;
      abort_r    <= 1'b0;
      done_r     <= 1'b0;
      crc_err_r  <= 1'b0;
      vote_err_r <= 1'b0;
      stall_r    <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      vld_r <= 1'b0;
      if (byte_cnt != {CNT_W{1'b1}}) byte_cnt <= byte_cnt + 1'b1;

      if (state == ST_IDLE) begin
        decode_q  <= bus.DECODE;
        crc_ena_q <= bus.CRC_ENA;
      end

      if (active) begin
        phase <= last_byte ? 3'd0 : phase + 3'd1;
        if (!phase[0])      lo_byte <= bus.PARAM_DAT;
        if (phase == 3'd1)  copy0   <= cur_word;
        if (phase == 3'd3)  copy1   <= cur_word;
      end

      if (word_done) begin
        crc  <= crc_next;
        widx <= widx + 1'b1;
        if (bus.FF_FULL) begin
          stall_r <= 1'b1;
        end else begin
          vld_r  <= 1'b1;
          word_r <= data_word;
        end
        if (decode_eff && ((copy0 != copy1) || (copy0 != cur_word))) vote_err_r <= 1'b1;
        if (state == ST_HDR) begin
          if (data_word == HEADER) hdr_ok_r <= 1'b1;
          else                     abort_r  <= 1'b1;
        end
        if ((state == ST_DATA) && (widx == WIDX_W'(NWORDS - 1)) && !crc_ena_q) done_r <= 1'b1;
      end

      if (crc_done) begin
        crc_err_r <= (cur_word != crc);
        done_r    <= 1'b1;
      end
    end
  end

  assign bus.WORD      = word_r;
  assign bus.WORD_VLD  = vld_r;
  assign bus.HDR_OK    = hdr_ok_r;
  assign bus.ABORT     = abort_r;
  assign bus.SEQ_DONE  = done_r;
  assign bus.CRC_ERR   = crc_err_r;
  assign bus.VOTE_ERR  = vote_err_r;
  assign bus.STALL     = stall_r;
  assign bus.BYTE_CNT  = byte_cnt;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_prom_param_reader.sv
// Randomised scoreboard bench for prom_param_reader: a PROM image model feeds bytes, a
// reference model predicts the emitted words and status flags.
module tb_prom_param_reader;
  import prom_pkg::*;

  logic PARAM_CLK = 1'b0;
  logic prm_rst   = 1'b1;

  prom_param_reader_if bus ();

  prom_param_reader dut (
    .PARAM_CLK (PARAM_CLK),
    .prm_rst   (prm_rst),
    .bus       (bus)
  );

  // ---------------- clock / reset / PROM model ----------------
  always #5 PARAM_CLK = ~PARAM_CLK;

  logic [7:0] prom [0:1023];
  int         addr;
  int         edges;
  logic       full_en = 1'b0;
  int         full_lo = 0;
  int         full_hi = 0;

  // PROM address counter leaves reset together with the reader: two sync edges, then one byte per edge.
  always @(posedge PARAM_CLK or posedge prm_rst) begin
    if (prm_rst) begin
      edges <= 0;
      addr  <= 0;
    end else begin
      edges <= edges + 1;
      if (edges >= 2) addr <= addr + 1;
    end
  end

  assign bus.PARAM_DAT = prom[addr[9:0]];
  assign bus.FF_FULL   = full_en && (addr >= full_lo) && (addr <= full_hi);

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          vld_seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge PARAM_CLK) begin
    if (bus.WORD_VLD !== 1'b0) begin
      vld_seen++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL word_vld: unexpected strobe WORD=%h, required no strobe", bus.WORD);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.WORD !== e) begin
          mismatched++;
          $display("FAIL word: got %h, required %h", bus.WORD, e);
        end
      end
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [15:0] majority(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  function automatic logic [15:0] crc_of(input logic [15:0] ws[NWORDS]);
    logic [15:0] c;
    logic        top;
    c = CRC_INIT;
    for (int k = 0; k < NWORDS; k++) begin
      for (int b = 15; b >= 0; b--) begin
        top = c[15] ^ ws[k][b];
        c   = c << 1;
        if (top) c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

  function automatic logic [63:0] exp_byte_cnt();
    int n;
    n = (edges >= 2) ? edges - 2 : 0;
    if (n > 1023) n = 1023;
    return 64'(n);
  endfunction

  // ---------------- driver ----------------
  task automatic run_case(input string tag, input bit dec, input bit ce, input bit bad_hdr,
                          input bit corrupt, input bit flip, input bit full, input bit seq_data,
                          input int cut_after, input int extra_wait);
    logic [15:0] w  [NWORDS];
    logic [15:0] e  [NWORDS];
    logic [15:0] cp [NWORDS][3];
    logic [15:0] crc_w;
    bit          hdr_ok, vote_exp, crc_err_exp;
    int          bpw, p, ncopy, nbytes, guard;

    @(negedge PARAM_CLK);
    prm_rst     = 1'b1;
    full_en     = 1'b0;
    bus.DECODE  = dec;
    bus.CRC_ENA = ce;
    exp_q.delete();
    vld_seen    = 0;

    ncopy = dec ? 3 : 1;
    bpw   = 2 * ncopy;
    for (int a = 0; a < 1024; a++) prom[a] = 8'($urandom);
    vote_exp = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      if (i == 0)        w[i] = bad_hdr ? 16'h1234 : HEADER;
      else if (seq_data) w[i] = 16'(i);
      else               w[i] = 16'($urandom);
      for (int c = 0; c < 3; c++) cp[i][c] = w[i];
    end
    if (corrupt) begin
      for (int i = 2; i < NWORDS; i += 5) begin
        cp[i][$urandom_range(0, ncopy - 1)] ^= 16'($urandom_range(1, 65535));
        vote_exp = dec;
      end
    end
    if (flip) begin
      logic [15:0] m;
      m = 16'h0001 << $urandom_range(0, 15);
      for (int c = 0; c < 3; c++) cp[7][c] ^= m;
    end
    crc_w = crc_of(w);

    p = 0;
    for (int i = 0; i < NWORDS; i++) begin
      for (int c = 0; c < ncopy; c++) begin
        prom[p] = cp[i][c][7:0];
        prom[p + 1] = cp[i][c][15:8];
        p += 2;
      end
      e[i] = dec ? majority(cp[i][0], cp[i][1], cp[i][2]) : cp[i][0];
    end
    if (ce) begin
      prom[p] = crc_w[7:0];
      prom[p + 1] = crc_w[15:8];
      p += 2;
    end
    nbytes = p;

    hdr_ok      = (e[0] == HEADER);
    crc_err_exp = hdr_ok && ce && (crc_of(e) != crc_w);
    if (hdr_ok) begin
      for (int i = 0; i < NWORDS; i++)
        if (!(full && (i == 3 || i == 4))) exp_q.push_back(e[i]);
    end else begin
      exp_q.push_back(e[0]);
    end

    repeat (2) @(negedge PARAM_CLK);
    check({tag, " reset_outputs"},
          64'({bus.WORD, bus.WORD_VLD, bus.HDR_OK, bus.ABORT, bus.SEQ_DONE, bus.CRC_ERR,
               bus.VOTE_ERR, bus.STALL, bus.BYTE_CNT}), 64'h0);
    check({tag, " reset_state"}, 64'(bus.state_dbg), 64'(ST_IDLE));

    full_lo = 4 * bpw - 1;
    full_hi = 5 * bpw - 1;
    full_en = full;
    prm_rst = 1'b0;

    if (cut_after >= 0) begin
      guard = 0;
      while (vld_seen <= cut_after && guard < 400) begin
        @(negedge PARAM_CLK);
        guard++;
      end
      check({tag, " cut_timeout"}, 64'(guard >= 400), 64'h0);
      prm_rst = 1'b1;
      #1;
      check({tag, " async_reset_outputs"},
            64'({bus.WORD_VLD, bus.HDR_OK, bus.ABORT, bus.SEQ_DONE, bus.CRC_ERR,
                 bus.VOTE_ERR, bus.STALL, bus.BYTE_CNT}), 64'h0);
      exp_q.delete();
      return;
    end

    repeat (2 + nbytes + 8 + extra_wait) @(negedge PARAM_CLK);
    check({tag, " hdr_ok"},   64'(bus.HDR_OK),   64'(hdr_ok));
    check({tag, " abort"},    64'(bus.ABORT),    64'(!hdr_ok));
    check({tag, " seq_done"}, 64'(bus.SEQ_DONE), 64'(hdr_ok));
    check({tag, " crc_err"},  64'(bus.CRC_ERR),  64'(crc_err_exp));
    check({tag, " vote_err"}, 64'(bus.VOTE_ERR), 64'(vote_exp && hdr_ok));
    check({tag, " stall"},    64'(bus.STALL),    64'(full && hdr_ok));
    check({tag, " byte_cnt"}, 64'(bus.BYTE_CNT), exp_byte_cnt());
    check({tag, " words_left"}, 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.DECODE  = 1'b0;
    bus.CRC_ENA = 1'b0;
    //          tag          dec ce  bad cor flp ful seq cut  extra
    run_case("plain",        0,  0,  0,  0,  0,  0,  1,  -1,  0);
    run_case("bad_hdr",      0,  0,  1,  0,  0,  0,  0,  -1,  0);
    run_case("decode_vote",  1,  0,  0,  1,  0,  0,  0,  -1,  0);
    run_case("crc_ok",       0,  1,  0,  0,  0,  0,  0,  -1,  0);
    run_case("crc_flip",     0,  1,  0,  0,  1,  0,  0,  -1,  0);
    run_case("fifo_full",    0,  0,  0,  0,  0,  1,  1,  -1,  0);
    run_case("dec_crc_full", 1,  1,  0,  1,  0,  1,  0,  -1,  0);
    run_case("mid_reset",    0,  0,  0,  0,  0,  0,  1,  10,  0);
    run_case("restart",      0,  0,  0,  0,  0,  0,  1,  -1,  0);
    for (int r = 0; r < 3; r++)
      run_case("random", 1'($urandom), 1'($urandom), 0, 1'($urandom), 0, 1'($urandom), 0, -1, 0);
    run_case("saturate",     0,  0,  0,  0,  0,  0,  0,  -1,  1100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

endmodule
